// File: rtl/recompositor_division_iterativo.sv
// Dividend reconstructor / signed multiply-accumulate: Prod = Coc*Den + Res.
// The signed product is built by an iterative radix-2 shift-add multiplier
// on operand magnitudes, followed by a one-cycle sign fix and addend step.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous active-high reset
//   Start request, sampled only while Busy=0
//   Coc   signed multiplicand (quotient)
//   Den   signed multiplier (divisor)
//   Res   signed addend (remainder)
//   Prod  signed 2*tamanyo-bit result Coc*Den+Res
//   Num   low tamanyo bits of Prod
//   Ovf   Prod not representable as a tamanyo-bit signed value
//   Busy  operation in progress
//   Done  one-cycle pulse, results valid
module recompositor_division_iterativo #(
    parameter int unsigned tamanyo = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   Start,
    input  logic [tamanyo-1:0]     Coc,
    input  logic [tamanyo-1:0]     Den,
    input  logic [tamanyo-1:0]     Res,
    output logic [2*tamanyo-1:0]   Prod,
    output logic [tamanyo-1:0]     Num,
    output logic                   Ovf,
    output logic                   Busy,
    output logic                   Done
);

    localparam int unsigned W  = tamanyo;
    localparam int unsigned W2 = 2 * tamanyo;
    localparam int unsigned CW = $clog2(tamanyo + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    res_q, res_d;
    logic            sign_q, sign_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W2-1:0]   prod_d;
    logic [W-1:0]    num_d;
    logic            ovf_d, busy_d, done_d;

    logic [W:0]      sum_c;
    logic [W2-1:0]   fix_val_c;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; counter reaching 1 means the last iteration runs now
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_d    = res_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        prod_d   = Prod;
        num_d    = Num;
        ovf_d    = Ovf;
        done_d   = 1'b0;
        busy_d   = (state_d != IDLE);

        // Upper-half add with carry-out kept as bit W
        sum_c     = {1'b0, acc_q[W2-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : W'(0))};
        fix_val_c = (sign_q ? (~acc_q + W2'(1)) : acc_q) + {{W{res_q[W-1]}}, res_q};

        case (state_q)
            IDLE: begin
                if (Start) begin
                    // Most-negative operand negates to 2^(W-1), valid unsigned
                    mcand_d  = Coc[W-1] ? (~Coc + W'(1)) : Coc;
                    mplier_d = Den[W-1] ? (~Den + W'(1)) : Den;
                    sign_d   = Coc[W-1] ^ Den[W-1];
                    res_d    = Res;
                    acc_d    = '0;
                    cnt_d    = CW'(W);
                end
            end
            CALC: begin
                // Shift {carry, acc, multiplier} right by one
                acc_d    = {sum_c, acc_q[W-1:1]};
                mplier_d = {acc_q[0], mplier_q[W-1:1]};
                cnt_d    = cnt_q - CW'(1);
            end
            FIX: begin
                prod_d = fix_val_c;
                num_d  = fix_val_c[W-1:0];
                // Fits in W signed bits only if bits [W2-1:W-1] are all equal
                ovf_d  = !((&fix_val_c[W2-1:W-1]) || !(|fix_val_c[W2-1:W-1]));
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            Prod     <= '0;
            Num      <= '0;
            Ovf      <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_q    <= res_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            Prod     <= prod_d;
            Num      <= num_d;
            Ovf      <= ovf_d;
            Busy     <= busy_d;
            Done     <= done_d;
        end
    end

    a_done_after_fix: assert property (@(posedge CLK) disable iff (RST)
        Done |-> ($past(state_q) == FIX));
    a_busy_done_excl: assert property (@(posedge CLK)
        !(Busy && Done));
    a_busy_from_start: assert property (@(posedge CLK) disable iff (RST)
        $rose(Busy) |-> $past(Start));

endmodule

// File: tb/tb_recompositor_division_iterativo.sv
// Directed bench for recompositor_division_iterativo: vector table plus
// hand-written sequences for ignored starts, back-to-back issue and reset abort.
module tb_recompositor_division_iterativo;

    localparam int unsigned W   = 32;
    localparam int          LAT = 34;

    logic          CLK;
    logic          RST;
    logic          Start;
    logic [W-1:0]  Coc, Den, Res;
    logic [2*W-1:0] Prod;
    logic [W-1:0]  Num;
    logic          Ovf, Busy, Done;

    recompositor_division_iterativo #(.tamanyo(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start),
        .Coc(Coc), .Den(Den), .Res(Res),
        .Prod(Prod), .Num(Num), .Ovf(Ovf), .Busy(Busy), .Done(Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0]   coc;
        logic [W-1:0]   den;
        logic [W-1:0]   res;
        logic [2*W-1:0] prod;
        logic [W-1:0]   num;
        logic           ovf;
    } vec_t;

    vec_t vecs [11];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue one operation, scramble inputs after acceptance, wait for Done
    task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] r,
                          output logic [2*W-1:0] p, output logic [W-1:0] nm, output logic ov,
                          output int lat, output logic busy_ok);
        @(negedge CLK);
        Coc = c; Den = d; Res = r; Start = 1'b1;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                Start = 1'b0;
                Coc = $urandom; Den = $urandom; Res = $urandom;
            end
            if (Done) begin
                lat = k;
                if (Busy) busy_ok = 1'b0;
                break;
            end
            if (!Busy) busy_ok = 1'b0;
        end
        p = Prod; nm = Num; ov = Ovf;
    endtask

    logic [2*W-1:0] p;
    logic [W-1:0]   nm;
    logic           ov;
    int             lat;
    logic           bok;
    int             ndone;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{32'd7,          32'd3,          32'd2,          64'd23,                  32'd23,          1'b0};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFEA, 32'hFFFF_FFEA,   1'b0};
        vecs[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          64'h0000_0000_8000_0000, 32'h8000_0000,   1'b1};
        vecs[3]  = '{32'h4000_0000,  32'd4,          32'd0,          64'h0000_0001_0000_0000, 32'h0000_0000,   1'b1};
        vecs[4]  = '{32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFFD, 32'hFFFF_FFFD,   1'b0};
        vecs[5]  = '{32'h8000_0000,  32'h8000_0000,  32'd0,          64'h4000_0000_0000_0000, 32'h0000_0000,   1'b1};
        vecs[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0,                   32'h0,           1'b0};
        vecs[7]  = '{32'd12345,      32'hFFFF_FF9C,  32'd7,          64'hFFFF_FFFF_FFED_29C3, 32'hFFED_29C3,   1'b0};
        vecs[8]  = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_8000_0000, 32'h8000_0000,   1'b1};
        vecs[9]  = '{32'h8000_0000,  32'd1,          32'hFFFF_FFFF,  64'hFFFF_FFFF_7FFF_FFFF, 32'h7FFF_FFFF,   1'b1};
        vecs[10] = '{32'h8000_0000,  32'd1,          32'd0,          64'hFFFF_FFFF_8000_0000, 32'h8000_0000,   1'b0};

        RST = 1'b1; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
        repeat (3) @(negedge CLK);
        chk("reset prod", Prod, 64'd0);
        chk("reset busy", {63'd0, Busy}, 64'd0);
        chk("reset done", {63'd0, Done}, 64'd0);
        RST = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].coc, vecs[i].den, vecs[i].res, p, nm, ov, lat, bok);
            chk($sformatf("v%0d latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("v%0d prod", i), p, vecs[i].prod);
            chk($sformatf("v%0d num", i), {32'd0, nm}, {32'd0, vecs[i].num});
            chk($sformatf("v%0d ovf", i), {63'd0, ov}, {63'd0, vecs[i].ovf});
            chk($sformatf("v%0d busy", i), {63'd0, bok}, 64'd1);
        end

        // Starts while busy are ignored; Start in the Done cycle is accepted
        @(negedge CLK);
        Coc = 32'd7; Den = 32'd3; Res = 32'd2; Start = 1'b1;
        lat = 0; ndone = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (k == 1 || k == 6 || k == 11) Start = 1'b0;
            if (k == 5)  begin Start = 1'b1; Coc = 32'd100; Den = 32'd100; Res = 32'd0; end
            if (k == 10) begin Start = 1'b1; Coc = 32'd5;   Den = 32'hFFFF_FFFF; Res = 32'd9; end
            if (Done) begin lat = k; break; end
        end
        chk("busy-start latency", 64'(lat), 64'(LAT));
        chk("busy-start prod", Prod, 64'd23);
        Coc = 32'hFFFF_FFF9; Den = 32'd3; Res = 32'hFFFF_FFFF; Start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
            if (Done) begin lat = k; break; end
        end
        chk("b2b latency", 64'(lat), 64'(LAT));
        chk("b2b prod", Prod, 64'hFFFF_FFFF_FFFF_FFEA);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Done) ndone++;
        end
        chk("no extra done", 64'(ndone), 64'd0);
        chk("prod hold", Prod, 64'hFFFF_FFFF_FFFF_FFEA);

        // Reset mid-operation aborts, also overriding a same-edge Start
        @(negedge CLK);
        Coc = 32'd7; Den = 32'd3; Res = 32'd2; Start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            if (k == 1) Start = 1'b0;
            if (k == 15) begin RST = 1'b1; Start = 1'b1; end
        end
        Start = 1'b0;
        chk("abort busy", {63'd0, Busy}, 64'd0);
        chk("abort done", {63'd0, Done}, 64'd0);
        chk("abort prod", Prod, 64'd0);
        chk("abort num", {32'd0, Num}, 64'd0);
        chk("abort ovf", {63'd0, Ovf}, 64'd0);
        RST = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (Done || Busy) ndone++;
        end
        chk("abort quiet", 64'(ndone), 64'd0);
        run_op(32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFD, p, nm, ov, lat, bok);
        chk("post-reset latency", 64'(lat), 64'(LAT));
        chk("post-reset prod", p, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("post-reset num", {32'd0, nm}, 64'h0000_0000_FFFF_FFFD);
        chk("post-reset ovf", {63'd0, ov}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
